branch_predict_unit: RTL and testbench

Parametrised successor to the execute-stage branch resolver. It adds a direct-mapped branch history table of 2-bit saturating counters and a tagged branch target buffer, read by fetch. Execute-stage outcomes are resolved against the prediction carried down the pipeline; a redirect is raised only on a misprediction. A sticky halt state freezes prediction and redirect after `flag_halt`.

---
 rtl/branch_predict_unit.sv | 142 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BHT of 2-bit counters plus tagged BTB,
// read combinationally by fetch, trained by execute-stage resolution.
// Optional macro BRU_PERF_CNT_EN adds Br_Count / Mispred_Count outputs.
module branch_predict_unit #(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned BR_ADJ    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] F_PC,
  output logic            Pred_Taken,
  output logic [31:0]     Pred_Target,
  input  logic            Ex_Valid,
  input  logic [PC_W-1:0] Cur_PC,
  input  logic [31:0]     Imm,
  input  logic            Branch,
  input  logic            JmpSel,
  input  logic            JalrSel,
  input  logic [31:0]     AluResult,
  input  logic            Ex_PredTaken,
  input  logic [31:0]     Ex_PredTarget,
  input  logic            flag_halt,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel,
  output logic            Flush,
  output logic            Halted
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mispred_Count
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {RUN, HALT} state_t;

  state_t state_q, state_d;

  // Prediction tables, packed so reset and indexing stay simple
  logic [BHT_DEPTH-1:0]            vld_q;
  logic [BHT_DEPTH-1:0][1:0]       cnt_q;
  logic [BHT_DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [BHT_DEPTH-1:0][PC_W-1:0]  tgt_q;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             halted;
  logic             taken, mispred, is_ctl, upd, redirect;
  logic [31:0]      pc_full, pc_imm, pc_four;
  logic [1:0]       cnt_inc, cnt_dec;
  logic             unused_fpc;

  assign f_idx      = F_PC[IDX_W+1:2];
  assign f_tag      = F_PC[PC_W-1:IDX_W+2];
  assign e_idx      = Cur_PC[IDX_W+1:2];
  assign e_tag      = Cur_PC[PC_W-1:IDX_W+2];
  assign halted     = (state_q == HALT);
  assign unused_fpc = ^F_PC[1:0];

  // Fetch lookup from registered tables (no bypass of same-cycle updates)
  always_comb begin
    f_hit       = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    Pred_Taken  = f_hit && cnt_q[f_idx][1] && !halted;
    Pred_Target = '0;
    if (Pred_Taken) Pred_Target = 32'(tgt_q[f_idx]);
  end

  // Execute-stage resolution against the piped prediction
  always_comb begin
    pc_full = 32'(Cur_PC);
    if (JalrSel)     pc_imm = AluResult;
    else if (JmpSel) pc_imm = pc_full + Imm;
    else             pc_imm = pc_full + Imm - 32'(BR_ADJ);
    pc_four  = (halted || flag_halt) ? 32'd0 : pc_full + 32'd4;
    taken    = (Branch && AluResult[0]) || JmpSel || JalrSel;
    mispred  = (taken != Ex_PredTaken) || (taken && (pc_imm != Ex_PredTarget));
    is_ctl   = Branch || JmpSel || JalrSel;
    upd      = Ex_Valid && is_ctl && !halted;
    redirect = upd && mispred;
    e_hit    = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
    cnt_inc  = (cnt_q[e_idx] == 2'b11) ? 2'b11 : cnt_q[e_idx] + 2'd1;
    cnt_dec  = (cnt_q[e_idx] == 2'b00) ? 2'b00 : cnt_q[e_idx] - 2'd1;
  end

  assign PC_Imm  = pc_imm;
  assign PC_Four = pc_four;
  assign BrPC    = taken ? pc_imm : pc_four;
  assign PcSel   = redirect;
  assign Flush   = redirect;
  assign Halted  = halted;

  // Halt next-state: sticky once entered
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && flag_halt) state_d = HALT;
  end

  // Halt state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Table training; a taken alias replaces the entry with a weakly-taken counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      cnt_q <= {BHT_DEPTH{2'b01}};
      tag_q <= '0;
      tgt_q <= '0;
    end else if (upd) begin
      if (taken) begin
        cnt_q[e_idx] <= e_hit ? cnt_inc : 2'b10;
        vld_q[e_idx] <= 1'b1;
        tag_q[e_idx] <= e_tag;
        tgt_q[e_idx] <= pc_imm[PC_W-1:0];
      end else if (e_hit) begin
        cnt_q[e_idx] <= cnt_dec;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Performance counters; both gated by RUN through upd
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Br_Count      <= '0;
      Mispred_Count <= '0;
    end else begin
      if (upd)      Br_Count      <= Br_Count + 32'd1;
      if (redirect) Mispred_Count <= Mispred_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: vector table plus halt/reset sequence.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  f_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [8:0]  cur_pc = '0;
  logic [31:0] imm = '0;
  logic        branch = 1'b0, jmp_sel = 1'b0, jalr_sel = 1'b0;
  logic [31:0] alu_result = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        flag_halt = 1'b0;
  logic [31:0] pc_imm, pc_four, br_pc;
  logic        pc_sel, flush, halted;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_count, mispred_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset_n(reset_n), .F_PC(f_pc),
    .Pred_Taken(pred_taken), .Pred_Target(pred_target),
    .Ex_Valid(ex_valid), .Cur_PC(cur_pc), .Imm(imm),
    .Branch(branch), .JmpSel(jmp_sel), .JalrSel(jalr_sel),
    .AluResult(alu_result), .Ex_PredTaken(ex_pred_taken),
    .Ex_PredTarget(ex_pred_target), .flag_halt(flag_halt),
    .PC_Imm(pc_imm), .PC_Four(pc_four), .BrPC(br_pc),
    .PcSel(pc_sel), .Flush(flush), .Halted(halted)
`ifdef BRU_PERF_CNT_EN
    , .Br_Count(br_count), .Mispred_Count(mispred_count)
`endif
  );

  typedef struct {
    string       name;
    logic        rn;
    logic [8:0]  fpc;
    logic        ev;
    logic [8:0]  cpc;
    logic [31:0] imm;
    logic        br, jmp, jalr;
    logic [31:0] alu;
    logic        xpt;
    logic [31:0] xtgt;
    logic        hlt;
    logic        chk;
    logic        ept;
    logic [31:0] etgt, eimm, efour, ebr;
    logic        epcsel, ehalt;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(string n, logic rn, logic [8:0] fpc, logic ev, logic [8:0] cpc,
                              logic [31:0] im, logic br, logic jmp, logic jalr, logic [31:0] alu,
                              logic xpt, logic [31:0] xtgt, logic hlt, logic chk, logic ept,
                              logic [31:0] etgt, logic [31:0] eimm, logic [31:0] efour,
                              logic [31:0] ebr, logic epcsel, logic ehalt);
    vec_t v;
    v.name = n; v.rn = rn; v.fpc = fpc; v.ev = ev; v.cpc = cpc; v.imm = im;
    v.br = br; v.jmp = jmp; v.jalr = jalr; v.alu = alu; v.xpt = xpt; v.xtgt = xtgt;
    v.hlt = hlt; v.chk = chk; v.ept = ept; v.etgt = etgt; v.eimm = eimm;
    v.efour = efour; v.ebr = ebr; v.epcsel = epcsel; v.ehalt = ehalt;
    return v;
  endfunction

  // Execute idle at Cur_PC=0x10, running: only the lookup varies
  function automatic vec_t idle(string n, logic [8:0] fpc, logic ept, logic [31:0] etgt);
    return mk(n, 1'b1, fpc, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
              1'b1, ept, etgt, 32'h08, 32'h14, 32'h14, 1'b0, 1'b0);
  endfunction

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", n, f, act, exp);
    end
  endtask

  // Pop the expected record and compare against the settled outputs
  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard actual=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp(e.name, "pred_taken",  32'(pred_taken),  32'(e.ept));
        cmp(e.name, "pred_target", pred_target,      e.etgt);
        cmp(e.name, "pc_imm",      pc_imm,           e.eimm);
        cmp(e.name, "pc_four",     pc_four,          e.efour);
        cmp(e.name, "br_pc",       br_pc,            e.ebr);
        cmp(e.name, "pc_sel",      32'(pc_sel),      32'(e.epcsel));
        cmp(e.name, "flush",       32'(flush),       32'(e.epcsel));
        cmp(e.name, "halted",      32'(halted),      32'(e.ehalt));
      end
    end
  endtask

  // Drive one cycle of stimulus after the edge, check at the falling edge
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset_n = v.rn; f_pc = v.fpc; ex_valid = v.ev; cur_pc = v.cpc; imm = v.imm;
    branch = v.br; jmp_sel = v.jmp; jalr_sel = v.jalr; alu_result = v.alu;
    ex_pred_taken = v.xpt; ex_pred_target = v.xtgt; flag_halt = v.hlt;
    exp_q.push_back(v);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    vec_t tbl[$];
    vec_t hs[$];

    tbl.push_back(mk("rst0", 1'b0, 9'h000, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("rst1", 1'b0, 9'h000, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(idle("reset_default", 9'h020, 1'b0, 32'h0));
    tbl.push_back(idle("reset_lookup_hi", 9'h1fc, 1'b0, 32'h0));
    tbl.push_back(mk("train1", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h58, 32'h24, 32'h58, 1'b1, 1'b0));
    tbl.push_back(idle("train1_lookup", 9'h020, 1'b1, 32'h58));
    tbl.push_back(mk("train2", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h58, 32'h58, 32'h24, 32'h58, 1'b0, 1'b0));
    tbl.push_back(mk("train3_sat", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h58, 32'h58, 32'h24, 32'h58, 1'b0, 1'b0));
    tbl.push_back(mk("decay1", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h58, 32'h58, 32'h24, 32'h24, 1'b1, 1'b0));
    tbl.push_back(mk("decay2", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h58, 32'h58, 32'h24, 32'h24, 1'b1, 1'b0));
    tbl.push_back(idle("decay_lookup", 9'h020, 1'b0, 32'h0));
    tbl.push_back(mk("floor_nt1", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h58, 32'h24, 32'h24, 1'b0, 1'b0));
    tbl.push_back(mk("floor_nt2", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h58, 32'h24, 32'h24, 1'b0, 1'b0));
    tbl.push_back(mk("floor_t", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h58, 32'h24, 32'h58, 1'b1, 1'b0));
    tbl.push_back(idle("floor_lookup", 9'h020, 1'b0, 32'h0));
    tbl.push_back(mk("jalr1", 1'b1, 9'h030, 1'b1, 9'h030, 32'h0, 1'b0, 1'b0, 1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h84, 32'h34, 32'h84, 1'b1, 1'b0));
    tbl.push_back(mk("jalr2", 1'b1, 9'h030, 1'b1, 9'h030, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h84, 1'b0, 1'b1, 1'b1, 32'h84, 32'h80, 32'h34, 32'h80, 1'b1, 1'b0));
    tbl.push_back(idle("jalr_lookup", 9'h030, 1'b1, 32'h80));
    tbl.push_back(mk("jal", 1'b1, 9'h040, 1'b1, 9'h040, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h140, 1'b0, 1'b1, 1'b0, 32'h0, 32'h140, 32'h44, 32'h140, 1'b0, 1'b0));
    tbl.push_back(idle("jal_lookup", 9'h040, 1'b1, 32'h140));
    tbl.push_back(mk("ex_invalid", 1'b1, 9'h000, 1'b0, 9'h000, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h04, 32'h10, 1'b0, 1'b0));
    tbl.push_back(idle("ex_invalid_lookup", 9'h040, 1'b1, 32'h140));
    tbl.push_back(mk("alias_t1", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h58, 32'h24, 32'h58, 1'b1, 1'b0));
    tbl.push_back(mk("alias_t2", 1'b1, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 32'h58, 32'h58, 32'h24, 32'h58, 1'b0, 1'b0));
    tbl.push_back(mk("alias_new", 1'b1, 9'h060, 1'b1, 9'h060, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h98, 32'h64, 32'h98, 1'b1, 1'b0));
    tbl.push_back(idle("alias_lookup", 9'h060, 1'b1, 32'h98));
    tbl.push_back(idle("alias_old", 9'h020, 1'b0, 32'h0));
    tbl.push_back(mk("alias_nt", 1'b1, 9'h060, 1'b1, 9'h060, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h98, 1'b0, 1'b1, 1'b1, 32'h98, 32'h98, 32'h64, 32'h64, 1'b1, 1'b0));
    tbl.push_back(idle("alias_nt_lookup", 9'h060, 1'b0, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // Halt entry, halted behaviour, reset release, and reset winning over halt/update
    hs.push_back(mk("halt_req", 1'b1, 9'h040, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h140, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0));
    hs.push_back(mk("halted_lookup", 1'b1, 9'h040, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b1));
    hs.push_back(mk("halted_branch", 1'b1, 9'h040, 1'b1, 9'h040, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h140, 32'h0, 32'h140, 1'b0, 1'b1));
    hs.push_back(mk("halt_reset", 1'b0, 9'h040, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b1));
    hs.push_back(idle("post_reset", 9'h040, 1'b0, 32'h0));
    hs.push_back(mk("reset_race", 1'b0, 9'h020, 1'b1, 9'h020, 32'h40, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h58, 32'h0, 32'h58, 1'b1, 1'b0));
    hs.push_back(idle("post_race", 9'h020, 1'b0, 32'h0));
    hs.push_back(idle("post_race_run", 9'h040, 1'b0, 32'h0));

    foreach (hs[i]) apply(hs[i]);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
